// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: TXDATA store pushes a byte into a small FIFO, STATUS load reads flags.
// Latency: a push at edge k drives the start bit from edge k+1; the load path is combinational.
// Backpressure: a store while the FIFO is full is dropped and latches the sticky ovf flag.
module uart_tx_mmio #(
    parameter int          CLK_DIV    = 16,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_FF00
) (
    input  logic        i_clk,
    input  logic        i_arst,
    input  logic        i_we,
    input  logic [31:0] i_address,
    input  logic [31:0] i_write_data,
    output logic [31:0] o_read_data,
    output logic        o_tx,
    output logic        o_busy
);
    localparam int          AW          = $clog2(FIFO_DEPTH);
    localparam int          CW          = AW + 1;
    localparam int          BW          = $clog2(CLK_DIV);
    localparam logic [31:0] STATUS_ADDR = BASE_ADDR + 32'd4;
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t         r_state, w_state_nxt;
    logic [7:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]  r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic           r_ovf;
    logic [7:0]     r_shift, w_shift_nxt;
    logic [2:0]     r_bit_cnt, w_bit_nxt;
    logic [BW-1:0]  r_baud, w_baud_nxt;
    logic           r_tx, w_tx_nxt;

    logic w_hit_data, w_hit_stat, w_full, w_empty, w_push, w_pop, w_baud_wrap, w_busy;

    assign w_hit_data  = (i_address == BASE_ADDR);
    assign w_hit_stat  = (i_address == STATUS_ADDR);
    assign w_full      = (r_count == DEPTH_C);
    assign w_empty     = (r_count == '0);
    // Full is judged on the pre-edge count, so a same-edge pop cannot rescue a push into a full FIFO.
    assign w_push      = i_we & w_hit_data & ~w_full;
    assign w_pop       = (r_state == S_IDLE) & ~w_empty;
    assign w_baud_wrap = (r_baud == BAUD_LAST);
    assign w_busy      = (r_state != S_IDLE) | ~w_empty;

    assign o_busy      = w_busy;
    assign o_tx        = r_tx;
    assign o_read_data = w_hit_stat ? {28'd0, r_ovf, w_full, w_empty, w_busy} : 32'd0;

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_write_data[7:0];
    end

    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (i_we && w_hit_data && w_full) r_ovf <= 1'b1;
            else if (i_we && w_hit_stat)      r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_baud    <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_baud    <= w_baud_nxt;
            r_tx      <= w_tx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_bit_nxt   = r_bit_cnt;
        w_baud_nxt  = w_baud_wrap ? '0 : r_baud + BW'(1);
        case (r_state)
            S_IDLE: begin
                w_baud_nxt = '0;
                if (!w_empty) begin
                    w_state_nxt = S_START;
                    w_shift_nxt = r_mem[r_rd_ptr];
                    w_bit_nxt   = '0;
                end
            end
            S_START: if (w_baud_wrap) w_state_nxt = S_DATA;
            S_DATA: begin
                if (w_baud_wrap) begin
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                        w_bit_nxt   = r_bit_cnt + 3'd1;
                    end
                end
            end
            S_STOP: if (w_baud_wrap) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        // The line level is registered from the next state so o_tx changes exactly on state edges.
        case (w_state_nxt)
            S_START: w_tx_nxt = 1'b0;
            S_DATA:  w_tx_nxt = w_shift_nxt[0];
            default: w_tx_nxt = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio against a frame-schedule model of the transmitter.
module tb_uart_tx_mmio;
    localparam int          D     = 4;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_FF00;
    localparam logic [31:0] STAT  = 32'h0000_FF04;

    logic        clk    = 1'b0;
    logic        arst_n = 1'b1;
    logic        we     = 1'b0;
    logic [31:0] addr   = STAT;
    logic [31:0] wdata  = 32'd0;
    logic [31:0] rdata;
    logic        tx, busy;

    always #5 clk = ~clk;

    uart_tx_mmio #(.CLK_DIV(D), .FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .i_clk(clk), .i_arst(arst_n), .i_we(we), .i_address(addr),
        .i_write_data(wdata), .o_read_data(rdata), .o_tx(tx), .o_busy(busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: each accepted byte gets a push edge and a frame-start edge; the line is derived from those.
    int         m_push[$];
    int         m_start[$];
    logic [7:0] m_byte[$];
    int         m_last_end = -100;
    logic       m_ovf      = 1'b0;

    function automatic int m_count(input int t);
        int n;
        n = 0;
        foreach (m_push[i]) if (m_push[i] <= t && m_start[i] > t) n++;
        return n;
    endfunction

    function automatic logic exp_tx(input int t);
        int idx;
        foreach (m_start[i]) begin
            if (t >= m_start[i] && t < m_start[i] + 10 * D) begin
                idx = (t - m_start[i]) / D;
                if (idx == 0) return 1'b0;
                if (idx == 9) return 1'b1;
                return m_byte[i][idx-1];
            end
        end
        return 1'b1;
    endfunction

    function automatic logic exp_busy(input int t);
        foreach (m_push[i]) if (m_push[i] <= t && t < m_start[i] + 10 * D) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] exp_status(input int t);
        int n;
        n = m_count(t);
        return {28'd0, m_ovf, (n == DEPTH), (n == 0), exp_busy(t)};
    endfunction

    task automatic model_store(input int t, input logic [31:0] a, input logic [31:0] d);
        int s;
        if (a == BASE) begin
            if (m_count(t - 1) >= DEPTH) begin
                m_ovf = 1'b1;
            end else begin
                s = (t + 1 > m_last_end + 1) ? t + 1 : m_last_end + 1;
                m_push.push_back(t);
                m_start.push_back(s);
                m_byte.push_back(d[7:0]);
                m_last_end = s + 10 * D;
            end
        end else if (a == STAT) begin
            m_ovf = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_push.delete();
        m_start.delete();
        m_byte.delete();
        m_last_end = -100;
        m_ovf = 1'b0;
    endtask

    // One bus cycle; returns 1 ns after the following falling edge with the address parked on STATUS.
    task automatic step(input logic s_we, input logic [31:0] s_addr, input logic [31:0] s_data);
        we = s_we; addr = s_addr; wdata = s_data;
        @(posedge clk);
        cyc++;
        if (s_we) model_store(cyc, s_addr, s_data);
        @(negedge clk);
        we = 1'b0; addr = STAT; wdata = 32'd0;
        #1;
    endtask

    function automatic logic [31:0] rand_other_addr();
        logic [31:0] a;
        a = $urandom;
        if (a == BASE || a == STAT) a = 32'h0000_FF08;
        return a;
    endfunction

    task automatic test_reset();
        #2 arst_n = 1'b0;
        model_reset();
        #1;
        if (rdata !== 32'h2) begin errors++; $display("FAIL reset_status got=%h exp=%h", rdata, 32'h2); end
        if (tx !== 1'b1)     begin errors++; $display("FAIL reset_tx got=%b exp=1", tx); end
        if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks += 3;
        repeat (2) @(posedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        step(1'b0, STAT, 32'd0);
        if (rdata !== 32'h2) begin errors++; $display("FAIL post_reset_status got=%h exp=%h", rdata, 32'h2); end
        if (tx !== 1'b1)     begin errors++; $display("FAIL post_reset_tx got=%b exp=1", tx); end
        checks += 2;
    endtask

    task automatic test_single_frame();
        int k, idx;
        logic [9:0] pat;
        pat = {1'b1, 8'hA5, 1'b0};
        step(1'b1, BASE, 32'hDEAD_BEA5);
        k = cyc;
        for (int i = 0; i < 46; i++) begin
            if (tx !== exp_tx(cyc))         begin errors++; $display("FAIL single_tx cyc=%0d got=%b exp=%b", cyc, tx, exp_tx(cyc)); end
            if (busy !== exp_busy(cyc))     begin errors++; $display("FAIL single_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy(cyc)); end
            if (rdata !== exp_status(cyc))  begin errors++; $display("FAIL single_status cyc=%0d got=%h exp=%h", cyc, rdata, exp_status(cyc)); end
            checks += 3;
            if (cyc >= k + 1 && cyc < k + 41) begin
                idx = (cyc - k - 1) / D;
                if (tx !== pat[idx]) begin errors++; $display("FAIL single_pattern cyc=%0d got=%b exp=%b", cyc, tx, pat[idx]); end
                checks++;
            end
            if (cyc == k + 41) begin
                if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got=%b exp=0", busy); end
                checks++;
            end
            step(1'b0, STAT, 32'd0);
        end
    endtask

    task automatic test_decode();
        step(1'b1, 32'h0000_FF08, $urandom);
        if (rdata !== exp_status(cyc)) begin errors++; $display("FAIL decode_status got=%h exp=%h", rdata, exp_status(cyc)); end
        checks++;
        step(1'b1, rand_other_addr(), $urandom);
        if (rdata !== 32'h2) begin errors++; $display("FAIL decode_unmapped_store got=%h exp=%h", rdata, 32'h2); end
        checks++;
        addr = BASE; #1;
        if (rdata !== 32'd0) begin errors++; $display("FAIL decode_load_txdata got=%h exp=0", rdata); end
        checks++;
        addr = rand_other_addr(); #1;
        if (rdata !== 32'd0) begin errors++; $display("FAIL decode_load_other got=%h exp=0", rdata); end
        checks++;
        addr = STAT;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, STAT, 32'd0);
            if (tx !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL decode_line cyc=%0d tx=%b busy=%b exp tx=1 busy=0", cyc, tx, busy); end
            checks++;
        end
    endtask

    task automatic test_overflow();
        step(1'b1, BASE, {24'h0, 8'($urandom)});
        step(1'b0, STAT, 32'd0);
        step(1'b0, STAT, 32'd0);
        for (int b = 1; b <= 5; b++) step(1'b1, BASE, {$urandom_range(0, 255), 8'(b)} & 32'hFFFF_FFFF);
        if (rdata !== exp_status(cyc)) begin errors++; $display("FAIL ovf_status got=%h exp=%h", rdata, exp_status(cyc)); end
        if (rdata[3:2] !== 2'b11)      begin errors++; $display("FAIL ovf_full_flags got=%b exp=11", rdata[3:2]); end
        checks += 2;
        step(1'b1, STAT, $urandom);
        if (rdata[3] !== 1'b0)         begin errors++; $display("FAIL ovf_clear got=%b exp=0", rdata[3]); end
        if (rdata !== exp_status(cyc)) begin errors++; $display("FAIL ovf_clear_status got=%h exp=%h", rdata, exp_status(cyc)); end
        checks += 2;
        for (int i = 0; i < 5 * 41 + 8; i++) begin
            if (tx !== exp_tx(cyc))        begin errors++; $display("FAIL ovf_tx cyc=%0d got=%b exp=%b", cyc, tx, exp_tx(cyc)); end
            if (rdata !== exp_status(cyc)) begin errors++; $display("FAIL ovf_drain_status cyc=%0d got=%h exp=%h", cyc, rdata, exp_status(cyc)); end
            checks += 2;
            step(1'b0, STAT, 32'd0);
        end
    endtask

    task automatic test_same_edge_push_pop();
        int p;
        step(1'b1, BASE, $urandom);
        step(1'b0, STAT, 32'd0);
        step(1'b1, BASE, $urandom);
        p = m_start[$];
        while (cyc < p - 1) begin
            if (tx !== exp_tx(cyc)) begin errors++; $display("FAIL same_edge_tx cyc=%0d got=%b exp=%b", cyc, tx, exp_tx(cyc)); end
            checks++;
            step(1'b0, STAT, 32'd0);
        end
        step(1'b1, BASE, $urandom);
        if (rdata[2:1] !== 2'b00)      begin errors++; $display("FAIL same_edge_count got=%b exp=00", rdata[2:1]); end
        if (rdata !== exp_status(cyc)) begin errors++; $display("FAIL same_edge_status got=%h exp=%h", rdata, exp_status(cyc)); end
        checks += 2;
        for (int i = 0; i < 2 * 41 + 6; i++) begin
            if (tx !== exp_tx(cyc))     begin errors++; $display("FAIL same_edge_tx cyc=%0d got=%b exp=%b", cyc, tx, exp_tx(cyc)); end
            if (busy !== exp_busy(cyc)) begin errors++; $display("FAIL same_edge_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy(cyc)); end
            checks += 2;
            step(1'b0, STAT, 32'd0);
        end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 9)       step(1'b1, BASE, $urandom);
            else if (r < 12) step(1'b1, STAT, $urandom);
            else if (r < 16) step(1'b1, rand_other_addr(), $urandom);
            else             step(1'b0, STAT, 32'd0);
            if (tx !== exp_tx(cyc))        begin errors++; $display("FAIL rand_tx cyc=%0d got=%b exp=%b", cyc, tx, exp_tx(cyc)); end
            if (busy !== exp_busy(cyc))    begin errors++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy(cyc)); end
            if (rdata !== exp_status(cyc)) begin errors++; $display("FAIL rand_status cyc=%0d got=%h exp=%h", cyc, rdata, exp_status(cyc)); end
            checks += 3;
        end
        while (cyc < m_last_end + 3) begin
            step(1'b0, STAT, 32'd0);
            if (tx !== exp_tx(cyc))        begin errors++; $display("FAIL rand_drain_tx cyc=%0d got=%b exp=%b", cyc, tx, exp_tx(cyc)); end
            if (rdata !== exp_status(cyc)) begin errors++; $display("FAIL rand_drain_status cyc=%0d got=%h exp=%h", cyc, rdata, exp_status(cyc)); end
            checks += 2;
        end
    endtask

    task automatic test_reset_mid_frame();
        int s0;
        step(1'b1, BASE, $urandom);
        s0 = m_start[$];
        for (int i = 0; i < 3; i++) step(1'b1, BASE, $urandom);
        while (cyc < s0 + 2 * D + 1) step(1'b0, STAT, 32'd0);
        if (busy !== 1'b1) begin errors++; $display("FAIL midframe_busy_before got=%b exp=1", busy); end
        checks++;
        #2 arst_n = 1'b0;
        model_reset();
        #1;
        if (tx !== 1'b1)     begin errors++; $display("FAIL midframe_tx_in_reset got=%b exp=1", tx); end
        if (busy !== 1'b0)   begin errors++; $display("FAIL midframe_busy_in_reset got=%b exp=0", busy); end
        if (rdata !== 32'h2) begin errors++; $display("FAIL midframe_status_in_reset got=%h exp=%h", rdata, 32'h2); end
        checks += 3;
        repeat (3) @(posedge clk);
        cyc += 3;
        @(negedge clk);
        arst_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            step(1'b0, STAT, 32'd0);
            if (tx !== 1'b1)     begin errors++; $display("FAIL post_abort_tx cyc=%0d got=%b exp=1", cyc, tx); end
            if (rdata !== 32'h2) begin errors++; $display("FAIL post_abort_status cyc=%0d got=%h exp=%h", cyc, rdata, 32'h2); end
            checks += 2;
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_decode();
        test_overflow();
        test_same_edge_push_pop();
        test_random();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
